// File: rtl/cdc_hs_pkg.sv
// rtl/cdc_hs_pkg.sv - shared types and defaults for the CDC handshake transmitter
package cdc_hs_pkg;

  typedef enum logic [0:0] {HS_IDLE, HS_WAIT} hs_state_e;

  localparam int HS_TIMEOUT_DEF = 1024;

  // Width of a counter that must hold 0..t; a disabled timeout (t=0) still gets one bit
  function automatic int tmo_width(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/data_sync.sv
// rtl/data_sync.sv - two-flop synchronizer cell for asynchronous level inputs
module data_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // First flop may go metastable; second flop gives it a full cycle to settle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cdc_hs_tx.sv
// rtl/cdc_hs_tx.sv - source side of a two-phase toggle req/ack CDC handshake
module cdc_hs_tx
  import cdc_hs_pkg::*;
#(
  parameter int DW      = 32,
  parameter int TIMEOUT = HS_TIMEOUT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             cdc_req,
  output logic [DW-1:0]    cdc_data,
  input  logic             cdc_ack,
  output logic             busy,
  output logic             err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] xfer_cnt
);

  localparam int            TW       = tmo_width(TIMEOUT);
  localparam bit            TMO_EN   = (TIMEOUT > 0);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TMO_EN ? TW'(TIMEOUT - 1) : '0;

  hs_state_e     state;
  hs_state_e     state_nxt;
  logic          ack_s;
  logic          alive;
  logic          accept;
  logic          done;
  logic          tick;
  logic          tmo_fire;
  logic [TW-1:0] tmo_cnt;

  // The only path from cdc_ack into this domain
  data_sync #(.W(1)) u_ack_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (cdc_ack),
    .q    (ack_s)
  );

  // State register; alive keeps in_ready low until the first edge after reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= HS_IDLE;
      alive <= 1'b0;
    end else begin
      state <= state_nxt;
      alive <= 1'b1;
    end
  end

  // Next state and handshake strobes; ack changes while idle are ignored
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    tick      = 1'b0;
    case (state)
      HS_IDLE: begin
        in_ready = alive;
        if (in_valid && alive) begin
          accept    = 1'b1;
          state_nxt = HS_WAIT;
        end
      end
      HS_WAIT: begin
        busy = 1'b1;
        if (ack_s == cdc_req) begin
          done      = 1'b1;
          state_nxt = HS_IDLE;
        end else begin
          tick = 1'b1;
        end
      end
      default: state_nxt = HS_IDLE;
    endcase
  end

  assign tmo_fire = TMO_EN && tick && (tmo_cnt == TMO_LAST);

  // Launch: capture the word and flip the request level in the same edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cdc_data <= '0;
      cdc_req  <= 1'b0;
    end else if (accept) begin
      cdc_data <= in_data;
      cdc_req  <= ~cdc_req;
    end
  end

  // Outstanding-wait counter, saturating at TIMEOUT
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt <= '0;
    end else if (accept) begin
      tmo_cnt <= '0;
    end else if (tick && (tmo_cnt != TMO_MAX)) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Sticky timeout flag; a set in the same cycle as err_clr wins
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (tmo_fire) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  // Completed-transfer counter, wrapping at 2^CNT_W
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      xfer_cnt <= '0;
    end else if (done) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb/tb_cdc_hs_tx.sv - self-checking bench for cdc_hs_tx with far-side ack model
module tb_cdc_hs_tx;

  localparam int TO = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          cdc_req;
  logic [31:0]   cdc_data;
  logic          cdc_ack = 1'b0;
  logic          busy;
  logic          err;
  logic          err_clr;
  logic [CW-1:0] xfer_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  cdc_hs_tx #(.DW(32), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .cdc_req  (cdc_req),
    .cdc_data (cdc_data),
    .cdc_ack  (cdc_ack),
    .busy     (busy),
    .err      (err),
    .err_clr  (err_clr),
    .xfer_cnt (xfer_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Far-side receiver: captures the word on each req change, answers after ack_delay cycles
  int          ack_delay = 3;
  bit          ack_en = 1'b1;
  int          spur_cnt = 0;
  bit          fs_seen = 1'b0;
  bit          fs_pend = 1'b0;
  int          fs_dly = 0;
  int          req_toggles = 0;
  logic [31:0] rx_q[$];

  always @(posedge clk) begin
    #2;
    if (!rstn) begin
      fs_seen = 1'b0;
      fs_pend = 1'b0;
      fs_dly  = 0;
      cdc_ack = 1'b0;
    end else begin
      if (cdc_req != fs_seen) begin
        fs_seen = cdc_req;
        rx_q.push_back(cdc_data);
        req_toggles++;
        fs_pend = 1'b1;
        fs_dly  = ack_delay;
      end else if (fs_dly > 0) begin
        fs_dly--;
      end
      if (fs_pend && fs_dly == 0 && ack_en) begin
        cdc_ack = fs_seen;
        fs_pend = 1'b0;
      end
      if (spur_cnt > 0) begin
        cdc_ack = ~cdc_ack;
        spur_cnt--;
      end
    end
  end

  // Reference model: transaction-level view of the transmitter, checked every cycle
  bit          m_req, m_busy, m_err, m_rdy, m_s1, m_s2;
  logic [31:0] m_data;
  int          m_cnt, m_wait;

  always @(negedge clk) begin
    bit set;
    if (!rstn) begin
      m_req = 0; m_busy = 0; m_err = 0; m_rdy = 0; m_s1 = 0; m_s2 = 0;
      m_data = '0; m_cnt = 0; m_wait = 0;
    end
    chk("mdl_cdc_req",  {31'b0, cdc_req},  {31'b0, m_req});
    chk("mdl_cdc_data", cdc_data,          m_data);
    chk("mdl_busy",     {31'b0, busy},     {31'b0, m_busy});
    chk("mdl_in_ready", {31'b0, in_ready}, {31'b0, m_rdy && !m_busy});
    chk("mdl_err",      {31'b0, err},      {31'b0, m_err});
    chk("mdl_xfer_cnt", {28'b0, xfer_cnt}, m_cnt);
    if (rstn) begin
      set = 1'b0;
      if (!m_busy) begin
        if (in_valid && m_rdy) begin
          m_data = in_data; m_req = !m_req; m_busy = 1; m_wait = 0;
        end
      end else if (m_s2 != m_req) begin
        if (m_wait < TO) begin
          m_wait++;
          if (m_wait == TO) set = 1'b1;
        end
      end else begin
        m_busy = 0;
        m_cnt  = (m_cnt + 1) % (1 << CW);
      end
      if (set) m_err = 1;
      else if (err_clr) m_err = 0;
      m_s2  = m_s1;
      m_s1  = cdc_ack;
      m_rdy = 1;
    end
  end

  task automatic send(input logic [31:0] w, input bit keep, output int t_acc);
    bit ok;
    ok = 1'b0;
    in_data  = w;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (in_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    t_acc = cyc;
    if (!keep) in_valid = 1'b0;
    chk("send_accepted", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_idle(input int max);
    for (int k = 0; k < max; k++) begin
      if (in_ready === 1'b1) break;
      @(posedge clk); #1;
    end
    chk("idle_reached", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tprev, tg0;
    rstn = 1'b0; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cdc_req",  {31'b0, cdc_req},  0);
    chk("rst_cdc_data", cdc_data,          0);
    chk("rst_busy",     {31'b0, busy},     0);
    chk("rst_err",      {31'b0, err},      0);
    chk("rst_xfer_cnt", {28'b0, xfer_cnt}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'b0, in_ready}, 1);

    // Single transfer with a 3-cycle far-side turnaround
    chk("req_before", {31'b0, cdc_req}, 0);
    send(32'hDEADBEEF, 1'b0, t);
    chk("req_flipped", {31'b0, cdc_req}, 1);
    chk("data_launch", cdc_data, 32'hDEADBEEF);
    chk("busy_wait",   {31'b0, busy}, 1);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk("data_held",  cdc_data, 32'hDEADBEEF);
      chk("ready_low",  {31'b0, in_ready}, 0);
    end
    @(posedge clk); #1;
    chk("ready_back_6", {31'b0, in_ready}, 1);
    chk("cnt_single",   {28'b0, xfer_cnt}, 1);
    chk("rx_single",    rx_q[0], 32'hDEADBEEF);

    // Back-to-back stream with instant loopback: accepts 4 cycles apart
    ack_delay = 0;
    rx_q.delete();
    tg0 = req_toggles;
    tprev = 0;
    for (int i = 1; i <= 8; i++) begin
      send(i, 1'b1, t);
      if (i > 1) chk("b2b_spacing", t - tprev, 4);
      tprev = t;
    end
    in_valid = 1'b0;
    wait_idle(50);
    chk("stream_rx_n", rx_q.size(), 8);
    for (int i = 0; i < 8; i++) chk("stream_rx_word", rx_q[i], i + 1);
    chk("stream_toggles", req_toggles - tg0, 8);
    chk("cnt_stream", {28'b0, xfer_cnt}, 9);

    // Timeout with ack withheld; err sticky until err_clr
    ack_en = 1'b0;
    send(32'hA5A50001, 1'b0, t);
    repeat (15) @(posedge clk);
    #1;
    chk("err_before_to", {31'b0, err}, 0);
    @(posedge clk); #1;
    chk("err_at_to", {31'b0, err}, 1);
    chk("busy_after_to", {31'b0, busy}, 1);
    ack_en = 1'b1;
    wait_idle(50);
    chk("cnt_after_to", {28'b0, xfer_cnt}, 10);
    chk("err_sticky",   {31'b0, err}, 1);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("err_cleared", {31'b0, err}, 0);

    // err_clr in the same cycle the timeout fires: set wins
    ack_en = 1'b0;
    send(32'hA5A50002, 1'b0, t);
    repeat (15) @(posedge clk);
    #1;
    err_clr = 1'b1;
    chk("err_pre_collision", {31'b0, err}, 0);
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("collision_set_wins", {31'b0, err}, 1);
    ack_en = 1'b1;
    wait_idle(50);
    chk("cnt_collision", {28'b0, xfer_cnt}, 11);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;

    // Asynchronous reset in the middle of a wait
    ack_delay = 3;
    send(32'h12345678, 1'b0, t);
    @(posedge clk); #1;
    chk("busy_pre_reset", {31'b0, busy}, 1);
    rstn = 1'b0;
    #1;
    chk("areset_req",  {31'b0, cdc_req},  0);
    chk("areset_busy", {31'b0, busy},     0);
    chk("areset_cnt",  {28'b0, xfer_cnt}, 0);
    chk("areset_data", cdc_data,          0);
    @(posedge clk); #1;
    rstn = 1'b1;
    send(32'hCAFEF00D, 1'b0, t);
    wait_idle(50);
    chk("post_reset_cnt", {28'b0, xfer_cnt}, 1);
    chk("post_reset_rx",  rx_q[$], 32'hCAFEF00D);

    // Spurious ack pulse while idle
    spur_cnt = 2;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("spur_ready", {31'b0, in_ready}, 1);
      chk("spur_cnt",   {28'b0, xfer_cnt}, 1);
    end

    // Counter wrap: 16 more transfers -> 17 total, 4-bit counter
    ack_delay = 0;
    for (int i = 0; i < 16; i++) begin
      send(32'h100 + i, 1'b0, t);
      wait_idle(50);
      if (i == 14) chk("wrap_zero", {28'b0, xfer_cnt}, 0);
    end
    chk("wrap_one", {28'b0, xfer_cnt}, 1);

    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cdc_hs_tx.md
Name: cdc_hs_tx

Overview:
- Source-side (transmit) end of a two-phase toggle request/acknowledge clock-domain-crossing handshake.
- Accepts a data word with valid/ready in the local clock domain and holds it stable on the crossing bus.
- Flips a request level, then waits for the far-side receiver to return a matching acknowledge level, which is asynchronous to the local clock.
- Includes a double-flop ack synchronizer, an outstanding-transfer timeout with a sticky error flag, and transfer counting for debug.

Parameters:
- DW, 32, width of the transferred data word.
- TIMEOUT, 1024, wait cycles before a timeout is flagged; 0 disables the timeout.
- CNT_W, 16, width of the completed-transfer counter; the counter wraps.

Ports:
- clk  input  1  local (source) clock.
- rstn  input  1  asynchronous active-low reset.
- in_valid  input  1  source has a word to send.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DW  word to send.
- cdc_req  output  1  request toggle level, driven straight from a flop.
- cdc_data  output  DW  held data bus, driven straight from flops.
- cdc_ack  input  1  acknowledge toggle from the far domain; asynchronous.
- busy  output  1  a transfer is outstanding.
- err  output  1  sticky timeout flag.
- err_clr  input  1  clears err.
- xfer_cnt  output  CNT_W  number of completed transfers.

Behaviour:
- Reset values while rstn is low:
  - cdc_req=0, cdc_data=0, busy=0, err=0, xfer_cnt=0, in_ready=0, state=IDLE, timeout counter=0.
  - Both ack sync flops = 0.
  - in_ready rises in the first cycle after rstn deasserts.
- Ack synchronizer:
  - ack_s is cdc_ack through two flops clocked by clk.
  - Nothing else samples cdc_ack directly.
- State IDLE:
  - in_ready=1, busy=0.
  - Accept occurs on in_valid && in_ready at edge N.
  - At edge N: cdc_data<=in_data; cdc_req<=~cdc_req; timeout counter<=0; state<=WAIT.
- State WAIT:
  - in_ready=0, busy=1.
  - cdc_data is held constant; this is the CDC guarantee.
  - Each cycle in which ack_s != cdc_req, the timeout counter increments, saturating at TIMEOUT.
  - When the counter reaches TIMEOUT (TIMEOUT>0): err<=1. The block stays in WAIT, because an issued toggle cannot be retracted.
  - When ack_s == cdc_req: state<=IDLE and xfer_cnt<=xfer_cnt+1 (wraps at 2^CNT_W). in_ready is 1 in the following cycle.
- Latency:
  - Minimum accept-to-accept period is 1 accept cycle + far-side ack turnaround + 2 sync cycles + 1 compare cycle.
  - With an instant far-side ack loopback, accepts are 4 cycles apart.
- Back-to-back requests: in_valid held high through WAIT is ignored until the state returns to IDLE. No data is lost or duplicated.
- err_clr:
  - err_clr=1 clears err at the next edge.
  - If err_clr and a timeout set occur in the same cycle, set wins.
- Glitch-freedom: cdc_req and cdc_data are flop outputs only, with no combinational logic after the flops.
- Reset mid-transfer:
  - Asynchronous return to reset values. The far side must be reset concurrently; this block does not re-align toggle phases.
- Ack toggling while IDLE is a protocol error. It is ignored and does not increment xfer_cnt.

Decomposition:
- Package cdc_hs_pkg holds:
  - typedef enum logic [0:0] {HS_IDLE, HS_WAIT} hs_state_e;
  - localparam HS_TIMEOUT_DEF = 1024.
- Sub-module: the ack synchronizer is one instance of the team's existing two-flop data_sync cell (d=cdc_ack, q=ack_s). Using that cell keeps technology-specific flop mapping in one place.
- Everything else is flat in cdc_hs_tx, with an expected implementation of about 150–200 lines.

Test Plan:
- Reset, then a single transfer:
  - Stimulus: far-side model returns ack 3 cycles after seeing cdc_req change; send in_data=0xDEADBEEF.
  - Required: cdc_req 0→1 at N+1; cdc_data=0xDEADBEEF held until done; in_ready low through WAIT and high again about 6 cycles later; xfer_cnt=1.
- Back-to-back stream:
  - Stimulus: in_valid held high with 8 distinct words, 0x1..0x8.
  - Required: the receiver captures exactly 0x1..0x8 in order; cdc_req toggles 8 times; xfer_cnt=8.
- Timeout:
  - Stimulus: TIMEOUT=16, ack withheld.
  - Required: err=1 exactly 16 WAIT cycles after the accept.
  - Then release ack: state returns to IDLE, xfer_cnt increments, and err stays 1 until err_clr, after which err=0 next cycle.
- Same-cycle collision: err_clr pulsed in the same cycle the timeout fires → err=1.
- Async reset mid-WAIT:
  - Stimulus: rstn low for 1 cycle while busy, ack model reset as well.
  - Required: cdc_req=0, busy=0, xfer_cnt=0 immediately; the next transfer completes normally.
- Counter wrap and spurious ack:
  - CNT_W=4 with 17 transfers → xfer_cnt=1.
  - A spurious ack toggle in IDLE → no count change and in_ready stays 1.
